// File: rtl/ddr3_rd_burst_ctrl_pkg.sv
// ddr3_rd_burst_ctrl_pkg: shared FSM encoding and AXI read constants
package ddr3_rd_burst_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, AR, R} state_t;
  localparam logic [2:0] AXI_SIZE_16B = 3'b100;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int unsigned BEAT_BYTES = 16;
endpackage

// File: rtl/ddr3_rd_burst_ctrl_if.sv
// ddr3_rd_burst_ctrl_if: AXI4 read address/data channels between master and MIG slave
interface ddr3_rd_burst_ctrl_if #(parameter int unsigned ADDR_W = 28);
  logic [ADDR_W-1:0] M_AXI_ARADDR;
  logic [7:0] M_AXI_ARLEN;
  logic [2:0] M_AXI_ARSIZE;
  logic [1:0] M_AXI_ARBURST;
  logic M_AXI_ARVALID;
  logic M_AXI_ARREADY;
  logic [127:0] M_AXI_RDATA;
  logic [1:0] M_AXI_RRESP;
  logic M_AXI_RLAST;
  logic M_AXI_RVALID;
  logic M_AXI_RREADY;
  modport master(
    output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID, M_AXI_RREADY,
    input M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
  );
  modport slave(
    input M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
  );
endinterface

// File: rtl/ddr3_rd_burst_ctrl_rd_addr_gen.sv
// rd_addr_gen: burst counter and linear frame address with wrap and frame_done pulse
module rd_addr_gen
  import ddr3_rd_burst_ctrl_pkg::*;
#(
  parameter int unsigned Brust_Length = 16,
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned FRAME_BASE = 0,
  parameter int unsigned FRAME_BEATS = 98304
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step,
  output logic [ADDR_W-1:0] addr,
  output logic frame_done
);
  localparam int unsigned NB = FRAME_BEATS / Brust_Length;
  localparam int CW = $clog2(NB + 1);
  logic [CW-1:0] cnt;
  logic wrap;
  assign wrap = cnt == CW'(NB - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr <= ADDR_W'(FRAME_BASE);
      cnt <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= step && wrap;
      if (step) begin
        addr <= wrap ? ADDR_W'(FRAME_BASE) : addr + ADDR_W'(Brust_Length * BEAT_BYTES);
        cnt <= wrap ? '0 : cnt + CW'(1);
      end
    end
endmodule

// File: rtl/ddr3_rd_burst_ctrl.sv
// ddr3_rd_burst_ctrl: AXI4 read-burst master streaming a frame buffer into the pixel FIFO.
// Define RD_RRESP_CHK_EN to add the sticky rd_err output for non-OKAY read responses.
module ddr3_rd_burst_ctrl
  import ddr3_rd_burst_ctrl_pkg::*;
#(
  parameter int unsigned Brust_Length = 16,
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned FRAME_BASE = 0,
  parameter int unsigned FRAME_BEATS = 98304
) (
  input  logic ui_clk_100MHZ,
  input  logic Rst_n,
  input  logic init_calib_complete,
  input  logic rdata_req,
  ddr3_rd_burst_ctrl_if.master axi,
  output logic [127:0] FIFO_WR_rdata,
  output logic rdata_fifo_Wr_en,
  output logic frame_done
`ifdef RD_RRESP_CHK_EN
  ,
  output logic rd_err
`endif
);
  state_t state;
  logic beat, last;
  assign beat = axi.M_AXI_RVALID && axi.M_AXI_RREADY;
  assign last = beat && axi.M_AXI_RLAST;
  assign axi.M_AXI_ARLEN = 8'(Brust_Length - 1);
  assign axi.M_AXI_ARSIZE = AXI_SIZE_16B;
  assign axi.M_AXI_ARBURST = AXI_BURST_INCR;
  assign rdata_fifo_Wr_en = beat;
  assign FIFO_WR_rdata = axi.M_AXI_RDATA;
  // rdata_req is only looked at in IDLE, keeping a single burst outstanding
  always_ff @(posedge ui_clk_100MHZ or negedge Rst_n)
    if (!Rst_n) begin
      state <= IDLE;
      axi.M_AXI_ARVALID <= 1'b0;
      axi.M_AXI_RREADY <= 1'b0;
    end else
      case (state)
        IDLE: if (init_calib_complete && rdata_req) begin
          state <= AR;
          axi.M_AXI_ARVALID <= 1'b1;
        end
        AR: if (axi.M_AXI_ARREADY) begin
          state <= R;
          axi.M_AXI_ARVALID <= 1'b0;
          axi.M_AXI_RREADY <= 1'b1;
        end
        R: if (last) begin
          state <= IDLE;
          axi.M_AXI_RREADY <= 1'b0;
        end
        default: state <= IDLE;
      endcase
  rd_addr_gen #(
    .Brust_Length(Brust_Length),
    .ADDR_W(ADDR_W),
    .FRAME_BASE(FRAME_BASE),
    .FRAME_BEATS(FRAME_BEATS)
  ) u_addr (
    .clk(ui_clk_100MHZ),
    .rst_n(Rst_n),
    .step(last),
    .addr(axi.M_AXI_ARADDR),
    .frame_done(frame_done)
  );
`ifdef RD_RRESP_CHK_EN
  always_ff @(posedge ui_clk_100MHZ or negedge Rst_n)
    if (!Rst_n) rd_err <= 1'b0;
    else if (beat && axi.M_AXI_RRESP != 2'b00) rd_err <= 1'b1;
`else
  logic unused_rresp;
  assign unused_rresp = ^axi.M_AXI_RRESP;
`endif
endmodule

// File: tb/tb_ddr3_rd_burst_ctrl.sv
// tb_ddr3_rd_burst_ctrl: directed bench with a beat scoreboard and a frame address model
module tb_ddr3_rd_burst_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, calib = 1'b0, req = 1'b0;
  logic [127:0] fdata;
  logic fwr, fdone;
  int total = 0, bad = 0, ar_hs = 0, done_cnt = 0, burst_no = 0;
  logic [27:0] exp_addr = '0;
  logic [127:0] sb[$];
  ddr3_rd_burst_ctrl_if #(.ADDR_W(28)) axi();
  ddr3_rd_burst_ctrl #(
    .Brust_Length(16), .ADDR_W(28), .FRAME_BASE(0), .FRAME_BEATS(64)
  ) dut (
    .ui_clk_100MHZ(clk), .Rst_n(rst_n), .init_calib_complete(calib), .rdata_req(req),
    .axi(axi), .FIFO_WR_rdata(fdata), .rdata_fifo_Wr_en(fwr), .frame_done(fdone)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (fwr) begin
      chk("fifo_nonempty", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) chk("fifo_data", fdata, sb.pop_front());
    end
    if (axi.M_AXI_ARVALID && axi.M_AXI_ARREADY) ar_hs++;
    if (fdone) done_cnt++;
  end
  task automatic burst(input int ar_dly, input bit gaps, input bit drop_req, input int rst_at);
    int n = 0;
    while (axi.M_AXI_ARVALID !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("arvalid_wait", axi.M_AXI_ARVALID, 1);
    chk("araddr", axi.M_AXI_ARADDR, exp_addr);
    repeat (ar_dly) begin
      @(posedge clk); #1;
      chk("araddr_hold", {axi.M_AXI_ARVALID, axi.M_AXI_ARADDR}, {1'b1, exp_addr});
    end
    axi.M_AXI_ARREADY = 1'b1;
    @(posedge clk); #1;
    axi.M_AXI_ARREADY = 1'b0;
    if (drop_req) req = 1'b0;
    chk("rready_up", {axi.M_AXI_ARVALID, axi.M_AXI_RREADY}, 2'b01);
    for (int b = 0; b < 16; b++) begin
      if (gaps && b > 0) begin
        axi.M_AXI_RVALID = 1'b0;
        @(posedge clk); #1;
      end
      axi.M_AXI_RDATA = {$urandom, $urandom, $urandom, $urandom};
      axi.M_AXI_RLAST = (b == 15);
      axi.M_AXI_RVALID = 1'b1;
      sb.push_back(axi.M_AXI_RDATA);
      if (b == rst_at) begin
        #1 rst_n = 1'b0;
        #1 chk("rst_outputs", {axi.M_AXI_ARVALID, axi.M_AXI_RREADY, fwr, fdone}, 4'b0);
        chk("rst_araddr", axi.M_AXI_ARADDR, 0);
        sb.delete();
        axi.M_AXI_RVALID = 1'b0;
        axi.M_AXI_RLAST = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_addr = '0;
        burst_no = 0;
        return;
      end
      @(posedge clk); #1;
    end
    axi.M_AXI_RVALID = 1'b0;
    axi.M_AXI_RLAST = 1'b0;
    burst_no++;
    chk("frame_done", fdone, 128'(burst_no == 4));
    exp_addr = (burst_no == 4) ? 28'h0 : exp_addr + 28'h100;
    burst_no = burst_no % 4;
    chk("idle_after_last", axi.M_AXI_ARVALID, 0);
    @(posedge clk); #1;
    chk("next_arvalid", axi.M_AXI_ARVALID, 128'(req && calib));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    axi.M_AXI_ARREADY = 1'b0;
    axi.M_AXI_RVALID = 1'b0;
    axi.M_AXI_RLAST = 1'b0;
    axi.M_AXI_RDATA = '0;
    axi.M_AXI_RRESP = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {axi.M_AXI_ARVALID, axi.M_AXI_RREADY, fwr, fdone}, 4'b0);
    chk("reset_araddr", axi.M_AXI_ARADDR, 0);
    rst_n = 1'b1;
    calib = 1'b1;
    req = 1'b1;
    @(posedge clk); #1;
    chk("arvalid_cycle1", axi.M_AXI_ARVALID, 1);
    chk("ar_consts", {axi.M_AXI_ARLEN, axi.M_AXI_ARSIZE, axi.M_AXI_ARBURST}, {8'd15, 3'd4, 2'd1});
    burst(5, 1'b1, 1'b0, -1);
    chk("ar_hs_once", ar_hs, 1);
    repeat (3) burst(0, 1'b0, 1'b0, -1);
    burst(0, 1'b0, 1'b1, -1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("no_ar_when_req_low", axi.M_AXI_ARVALID, 0);
    end
    req = 1'b1;
    burst(0, 1'b1, 1'b0, -1);
    burst(0, 1'b0, 1'b0, 7);
    burst(2, 1'b0, 1'b0, -1);
    chk("ar_handshakes", ar_hs, 8);
    chk("frame_done_count", done_cnt, 1);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ddr3_rd_burst_ctrl.md
# ddr3_rd_burst_ctrl

AXI4 read-burst master on the DDR3 user-interface clock. It streams a video frame buffer out of DDR3 into the 128-bit write side of the pixel read-data FIFO. It issues one fixed-length INCR burst whenever the FIFO raises `rdata_req`, forwards every returned beat as a FIFO write, and walks the frame address linearly, wrapping at the end of the frame. It sits between the MIG AXI slave port and the read-data FIFO controller.

## Interface
- `Brust_Length`, 16: beats per burst; `ARLEN = Brust_Length-1`; legal values 1..256.
- `ADDR_W`, 28: AXI byte-address width.
- `FRAME_BASE`, 0: byte address of the first beat of the frame.
- `FRAME_BEATS`, 98304: 128-bit beats per frame (1024x768x16 bit / 128); must be a multiple of `Brust_Length`.
- `ui_clk_100MHZ` in 1: single clock, MIG UI clock.
- `Rst_n` in 1: asynchronous active-low reset.
- `init_calib_complete` in 1: DDR3 calibration done; no request is issued while low.
- `rdata_req` in 1: FIFO has room for at least one burst.
- `M_AXI_ARADDR` out ADDR_W: burst start byte address.
- `M_AXI_ARLEN` out 8: constant `Brust_Length-1`.
- `M_AXI_ARSIZE` out 3: constant 3'b100 (16 B).
- `M_AXI_ARBURST` out 2: constant 2'b01 (INCR).
- `M_AXI_ARVALID` out 1 / `M_AXI_ARREADY` in 1: address handshake.
- `M_AXI_RDATA` in 128 / `M_AXI_RRESP` in 2 / `M_AXI_RLAST` in 1 / `M_AXI_RVALID` in 1: read data.
- `M_AXI_RREADY` out 1: data accept.
- `FIRST_WR_rdata` is not a port; the data-out port is `FIFO_WR_rdata` out 128: beat data to the FIFO.
- `rdata_fifo_Wr_en` out 1: FIFO write strobe.
- `frame_done` out 1: one-cycle pulse on completion of the last burst of a frame.

## Operation
- FSM has three states: `IDLE`, `AR`, `R`.
  - `IDLE` -> `AR` when `init_calib_complete && rdata_req`.
  - `AR`: `ARVALID`=1 and `ARADDR` is held stable until `ARREADY`; then -> `R`.
  - `R`: `RREADY`=1. The FIFO is guaranteed to have space because `rdata_req` was sampled before the burst. Exits to `IDLE` on a handshake with `RLAST`=1.
- `rdata_req` is sampled only in `IDLE`. Its level during `AR` and `R` is ignored, so only one burst is ever outstanding.
- FIFO write: `rdata_fifo_Wr_en = M_AXI_RVALID && M_AXI_RREADY`. `FIFO_WR_rdata = M_AXI_RDATA`. The path is combinational, with zero added latency.
- Address and beat accounting:
  - The burst counter counts bursts `0..FRAME_BEATS/Brust_Length-1`.
  - On the `RLAST` handshake, `ARADDR += Brust_Length*16`.
  - On the last burst of a frame, `ARADDR` instead reloads `FRAME_BASE`, the counter clears, and `frame_done` pulses on the same cycle.
- Bursts never cross a 4 KB boundary, provided `FRAME_BASE` is aligned to `Brust_Length*16`.
- `init_calib_complete` falling mid-burst: the burst finishes normally, and the FSM then stays in `IDLE`.
- `RRESP` is ignored unless the configuration macro is set; the data is always written.

## Timing
- Reset values:
  - `ARVALID`=0, `RREADY`=0, `rdata_fifo_Wr_en`=0, `frame_done`=0.
  - `ARADDR`=`FRAME_BASE`; burst counter=0; state=`IDLE`.
- `ARVALID` rises 1 cycle after `rdata_req` is sampled high in `IDLE`.
- After the `RLAST` handshake at cycle t:
  - The FSM is in `IDLE` at t+1.
  - The earliest next `ARVALID` is at t+2.
- `frame_done` is a registered pulse asserted the cycle after the final `RLAST` handshake.
- Reset asserted mid-burst clears everything immediately (asynchronous). Beats still in flight from the slave are dropped, because `RREADY`=0.

## Configuration
- `RD_RRESP_CHK_EN` defined: adds the output `rd_err` (1 bit, sticky, reset 0). It sets on any beat handshake with `RRESP != 2'b00`, and clears only by reset. An error beat is still written to the FIFO.
- `RD_RRESP_CHK_EN` undefined: no `rd_err` port, and `RRESP` is unused.

## Structure
- Shared package holds:
  - the FSM state encoding (`IDLE`/`AR`/`R`);
  - the AXI constants `AXI_SIZE_16B` and `AXI_BURST_INCR`;
  - the beat byte size constant 16.
- The block is a single module. A sub-module `rd_addr_gen` (burst counter, address increment, wrap, `frame_done`) is natural to isolate, but optional.

## Test plan
- Reset, then `init_calib_complete`=1 and `rdata_req`=1 -> `ARVALID` at cycle 1 with `ARADDR`=0, `ARLEN`=15, `ARSIZE`=4, `ARBURST`=1.
- `ARREADY` delayed 5 cycles -> `ARADDR` is stable throughout, and exactly one AR handshake occurs.
- 16 beats with `RVALID` toggling every other cycle -> 16 `rdata_fifo_Wr_en` pulses with matching data; next `ARADDR`=0x100.
- `FRAME_BEATS`=64 with `rdata_req` held high -> addresses 0x000, 0x100, 0x200, 0x300, then 0x000 again; `frame_done` pulses exactly once per wrap.
- `rdata_req` dropped during `R` -> the current burst completes and no new AR is issued; `rdata_req` raised again -> the next AR uses the advanced address.
- `Rst_n` pulsed low at beat 7 -> outputs are 0 immediately and the next AR is at `FRAME_BASE`. With `RD_RRESP_CHK_EN`, a beat with `RRESP`=2 sets `rd_err`=1 and it stays set.
